input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end conditioning stage for the microwave controller. It takes the raw asynchronous keypad lines, the start/stop/clear push-buttons and the door switch, synchronises each one to `clock`, and debounces it. It then presents clean levels to the top-level inputs of the microwave controller: the time-entry encoder, the timer and the magnetron control. Door opening uses a fast path, so the magnetron control sees an open door with minimum latency.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before a debounced level changes; must be ≥2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width; local, not overridable.

- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `keypad_raw` in 10: raw digit keys 0–9, active-high, asynchronous, bouncing.
- `startn_raw`, `stopn_raw`, `clearn_raw` in 1 each: raw buttons, active-low, asynchronous.
- `door_closed_raw` in 1: raw door switch, 1 = closed.
- `keypad` out 10: debounced keypad; one-hot or all-zero.
- `key_valid` out 1: 1 when exactly one debounced key is pressed.
- `startn`, `stopn`, `clearn` out 1 each: debounced, active-low.
- `door_closed` out 1: conditioned door state.

## Operation
- 14 independent channels (10 keys, 3 buttons, door). Each channel is a 2-flop synchroniser feeding a debounce cell that holds a stable state and a counter.
- Debounce cell behaviour, per clock:
  - If the synchronised sample equals the stable state, the counter clears to 0.
  - Otherwise the counter increments.
  - When the increment would reach `DEBOUNCE_CYCLES`, the stable state takes the sample and the counter clears.
  - Counter saturation is unreachable by construction.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles produce no output change. Each return to the stable value restarts the count from 0.
- Keypad qualification (combinational on debounced key states):
  - 0 keys stable-pressed: `keypad` = 0, `key_valid` = 0.
  - Exactly 1 key: `keypad` = that one-hot pattern, `key_valid` = 1.
  - 2 or more keys: `keypad` = 0, `key_valid` = 0. No priority encoding, so a digit is never guessed.
- Door fast path:
  - A synchronised 0 on the door channel forces the stable state to 0 immediately and clears its counter.
  - The transition from open to closed is debounced normally.
- Buttons are passed through without edge detection. Downstream logic consumes levels.

## Timing
- Reset values (asynchronous, all flops):
  - Synchroniser and stable flops of the active-low buttons are set to 1.
  - Key synchroniser and stable flops are set to 0.
  - Door synchroniser and stable flops are set to 0, i.e. door open, which is the safe state.
  - All counters are set to 0.
  - Resulting outputs: `keypad` = 0, `key_valid` = 0, `startn`/`stopn`/`clearn` = 1, `door_closed` = 0.
- Debounced latency: a raw change held steady appears on the output at the (`DEBOUNCE_CYCLES`+2)th rising edge after it is first sampled.
- Door-open latency: 2 edges (synchroniser only).
- `keypad` and `key_valid` change in the same cycle as the debounced key states; they add no register stage.
- Reset asserted mid-count discards the count. After reset deassertion every channel restarts from its reset state, so an input already held pressed needs the full debounce latency again.
- Simultaneous events:
  - Channels are fully independent.
  - Two keys crossing their thresholds in the same cycle yield `key_valid` = 0 from that cycle on.

## Configuration
- `KEYPAD_PULSE_EN` defined:
  - `keypad` is a single-cycle one-hot pulse, asserted in the cycle `key_valid` rises from 0 to 1.
  - A held key produces exactly one pulse.
  - The edge-detect register resets to 0.
  - `key_valid` remains a level.
- `KEYPAD_PULSE_EN` not defined: `keypad` is the level behaviour described above.

## Structure
- Shared package `input_conditioner_pkg` holds:
  - `NUM_KEYS` = 10
  - `NUM_BUTTONS` = 3
  - reset constants `BTN_IDLE` = 1, `KEY_IDLE` = 0, `DOOR_SAFE` = 0
- Sub-module `debounce_cell`:
  - Contains the synchroniser, counter and stable state.
  - Parameters: `DEBOUNCE_CYCLES`, `RESET_VAL`, `FAST_CLEAR`.
  - `FAST_CLEAR` = 1 only for the door channel.
  - Instantiated 14 times through a generate loop.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES` = 4.
- Reset release with all raw inputs idle -> outputs are `keypad` = 0, `startn` = `stopn` = `clearn` = 1, `door_closed` = 0.
- `keypad_raw` = 10'b0000100000 held steady -> `keypad` = 10'b0000100000 and `key_valid` = 1 at edge 6. With `KEYPAD_PULSE_EN`, exactly one cycle high.
- `startn_raw` toggled 0/1 every 2 cycles for 20 cycles -> `startn` stays 1 throughout.
- `door_closed` = 1 settled, then raw drops to 0 -> `door_closed` = 0 at edge 2. A 1-cycle raw dip also forces 0, followed by re-close after 6 edges.
- Keys 3 and 7 pressed together -> `keypad` = 0 and `key_valid` = 0. Release key 7 -> `keypad` = 10'b0000001000 after 6 edges.
- `reset` pulsed at count 3 while key 1 is held -> `keypad` = 0 immediately, and key 1 appears 6 edges after reset deassertion.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner: channel map, reset levels,
// and key-count qualification.
package input_conditioner_pkg;

    localparam int unsigned NUM_KEYS     = 10;
    localparam int unsigned NUM_BUTTONS  = 3;
    localparam int unsigned NUM_CHANNELS = NUM_KEYS + NUM_BUTTONS + 1;
    localparam int unsigned DOOR_CHAN    = NUM_CHANNELS - 1;
    localparam int unsigned KEY_CNT_W    = $clog2(NUM_KEYS + 1);

    localparam logic BTN_IDLE  = 1'b1;
    localparam logic KEY_IDLE  = 1'b0;
    localparam logic DOOR_SAFE = 1'b0;

    typedef enum logic [1:0] {
        ChanKey,
        ChanButton,
        ChanDoor
    } chan_kind_e;

    // Channel order: keys 0-9, then startn, stopn, clearn, then door.
    function automatic chan_kind_e chan_kind(input int unsigned idx);
        if (idx < NUM_KEYS) begin
            return ChanKey;
        end else if (idx < NUM_KEYS + NUM_BUTTONS) begin
            return ChanButton;
        end
        return ChanDoor;
    endfunction

    function automatic logic chan_reset_val(input int unsigned idx);
        case (chan_kind(idx))
            ChanKey:    return KEY_IDLE;
            ChanButton: return BTN_IDLE;
            default:    return DOOR_SAFE;
        endcase
    endfunction

    function automatic logic [KEY_CNT_W-1:0] count_keys(input logic [NUM_KEYS-1:0] keys);
        logic [KEY_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            n = n + KEY_CNT_W'(keys[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// One conditioning channel: 2-flop synchroniser, stable state and debounce counter.
// FAST_CLEAR makes a synchronised 0 win immediately (door-open path).
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_VAL       = 1'b0,
    parameter bit          FAST_CLEAR      = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q   <= RESET_VAL;
            sync_q   <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        meta_d   = raw;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (FAST_CLEAR && !sync_q) begin
            stable_d = 1'b0;
        end else if (sync_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The fast path reads the synchroniser directly so an open door is seen two edges
    // after it is sampled rather than waiting for the stable register.
    if (FAST_CLEAR) begin : g_fast
        assign level = stable_q & sync_q;
    end else begin : g_slow
        assign level = stable_q;
    end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces keypad, buttons and door switch for the microwave controller.
// Optional macro KEYPAD_PULSE_EN turns keypad into a one-cycle pulse on each new valid key.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keypad_raw,
    input  logic                startn_raw,
    input  logic                stopn_raw,
    input  logic                clearn_raw,
    input  logic                door_closed_raw,
    output logic [NUM_KEYS-1:0] keypad,
    output logic                key_valid,
    output logic                startn,
    output logic                stopn,
    output logic                clearn,
    output logic                door_closed
);

    logic [NUM_CHANNELS-1:0] chan_raw;
    logic [NUM_CHANNELS-1:0] chan_level;
    logic [NUM_KEYS-1:0]     key_level;
    logic                    key_one;

    assign chan_raw = {door_closed_raw, clearn_raw, stopn_raw, startn_raw, keypad_raw};

    for (genvar i = 0; i < int'(NUM_CHANNELS); i++) begin : g_chan
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (chan_reset_val(i)),
            .FAST_CLEAR      (i == int'(DOOR_CHAN))
        ) u_cell (
            .clock (clock),
            .reset (reset),
            .raw   (chan_raw[i]),
            .level (chan_level[i])
        );
    end

    assign key_level   = chan_level[NUM_KEYS-1:0];
    assign startn      = chan_level[NUM_KEYS];
    assign stopn       = chan_level[NUM_KEYS+1];
    assign clearn      = chan_level[NUM_KEYS+2];
    assign door_closed = chan_level[DOOR_CHAN];

    // Multiple keys are rejected outright rather than priority-encoded.
    assign key_one   = (count_keys(key_level) == KEY_CNT_W'(1));
    assign key_valid = key_one;

`ifdef KEYPAD_PULSE_EN
    logic valid_q, valid_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_comb begin
        valid_d = key_one;
        keypad  = '0;
        if (key_one && !valid_q) begin
            keypad = key_level;
        end
    end
`else
    always_comb begin
        keypad = '0;
        if (key_one) begin
            keypad = key_level;
        end
    end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Works in both the level build and the KEYPAD_PULSE_EN build.
module tb_input_conditioner;

`ifdef KEYPAD_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] keypad_raw;
    logic       startn_raw, stopn_raw, clearn_raw, door_closed_raw;
    logic [9:0] keypad;
    logic       key_valid, startn, stopn, clearn, door_closed;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    input_conditioner #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .keypad_raw      (keypad_raw),
        .startn_raw      (startn_raw),
        .stopn_raw       (stopn_raw),
        .clearn_raw      (clearn_raw),
        .door_closed_raw (door_closed_raw),
        .keypad          (keypad),
        .key_valid       (key_valid),
        .startn          (startn),
        .stopn           (stopn),
        .clearn          (clearn),
        .door_closed     (door_closed)
    );

    typedef struct {
        logic [9:0] keys;
        logic [9:0] exp_kp;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[10];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    logic [9:0] prev_kp;
    logic       prev_valid;
    logic       rose;

    initial begin
        vecs[0] = '{10'b0000100000, 10'b0000100000, 1'b1};
        vecs[1] = '{10'b0000000000, 10'b0000000000, 1'b0};
        vecs[2] = '{10'b0010001000, 10'b0000000000, 1'b0};
        vecs[3] = '{10'b0000001000, 10'b0000001000, 1'b1};
        vecs[4] = '{10'b0000000000, 10'b0000000000, 1'b0};
        vecs[5] = '{10'b0000000001, 10'b0000000001, 1'b1};
        vecs[6] = '{10'b1000000001, 10'b0000000000, 1'b0};
        vecs[7] = '{10'b0000000000, 10'b0000000000, 1'b0};
        vecs[8] = '{10'b1000000000, 10'b1000000000, 1'b1};
        vecs[9] = '{10'b0000000000, 10'b0000000000, 1'b0};

        reset           = 1'b1;
        keypad_raw      = '0;
        startn_raw      = 1'b1;
        stopn_raw       = 1'b1;
        clearn_raw      = 1'b1;
        door_closed_raw = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        check("reset_keypad", keypad, 10'b0);
        check("reset_valid", 10'(key_valid), 10'b0);
        check("reset_btns", 10'({startn, stopn, clearn}), 10'b111);
        check("reset_door", 10'(door_closed), 10'b0);

        // startn bounce with 2-cycle half period never debounces
        for (int c = 0; c < 20; c++) begin
            startn_raw = ((c >> 1) & 1) != 0;
            step(1);
            check("startn_bounce", 10'(startn), 10'b1);
        end
        startn_raw = 1'b1;
        step(6);
        check("startn_after_bounce", 10'(startn), 10'b1);

        // Door close is debounced, door open takes the synchroniser path only
        door_closed_raw = 1'b1;
        step(5);
        check("door_close_e5", 10'(door_closed), 10'b0);
        step(1);
        check("door_close_e6", 10'(door_closed), 10'b1);
        step(2);
        door_closed_raw = 1'b0;
        step(1);
        check("door_open_e1", 10'(door_closed), 10'b1);
        step(1);
        check("door_open_e2", 10'(door_closed), 10'b0);
        door_closed_raw = 1'b1;
        step(8);
        check("door_reclose", 10'(door_closed), 10'b1);
        door_closed_raw = 1'b0;
        step(1);
        door_closed_raw = 1'b1;
        step(1);
        check("door_dip_e2", 10'(door_closed), 10'b0);
        step(4);
        check("door_dip_e6", 10'(door_closed), 10'b0);
        step(1);
        check("door_dip_e7", 10'(door_closed), 10'b1);

        // Keypad qualification table; each entry checked one edge early, at, and after
        prev_kp    = '0;
        prev_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            keypad_raw = vecs[i].keys;
            step(5);
            check($sformatf("kp_pre[%0d]", i), keypad, PULSE ? 10'b0 : prev_kp);
            check($sformatf("kv_pre[%0d]", i), 10'(key_valid), 10'(prev_valid));
            step(1);
            rose = vecs[i].exp_valid && !prev_valid;
            check($sformatf("kp_at[%0d]", i), keypad,
                  (PULSE && !rose) ? 10'b0 : vecs[i].exp_kp);
            check($sformatf("kv_at[%0d]", i), 10'(key_valid), 10'(vecs[i].exp_valid));
            step(1);
            check($sformatf("kp_post[%0d]", i), keypad, PULSE ? 10'b0 : vecs[i].exp_kp);
            prev_kp    = vecs[i].exp_kp;
            prev_valid = vecs[i].exp_valid;
        end

        // Reset mid-count discards progress; the held key needs full latency again
        keypad_raw = 10'b0000000010;
        step(5);
        check("rst_mid_pre", keypad, 10'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_kp", keypad, 10'b0);
        check("rst_mid_kv", 10'(key_valid), 10'b0);
        step(1);
        reset = 1'b0;
        step(5);
        check("rst_after_e5", keypad, 10'b0);
        step(1);
        check("rst_after_e6", keypad, 10'b0000000010);
        check("rst_after_kv", 10'(key_valid), 10'b1);
        keypad_raw = '0;
        step(8);
        check("rst_release", 10'(key_valid), 10'b0);

        // Remaining buttons are independent levels
        stopn_raw = 1'b0;
        step(5);
        check("stopn_e5", 10'(stopn), 10'b1);
        step(1);
        check("stopn_e6", 10'({startn, stopn, clearn}), 10'b101);
        stopn_raw  = 1'b1;
        clearn_raw = 1'b0;
        step(6);
        check("clearn_low", 10'({startn, stopn, clearn}), 10'b110);
        clearn_raw = 1'b1;
        step(6);
        check("clearn_high", 10'(clearn), 10'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
